// File: rtl/mac_sched_pkg.sv
// Shared types for the MAC scheduler: FSM state encoding and the ID-width helper.
package mac_sched_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACC   = 2'd3
    } state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_sched_rr_arbiter.sv
// Round-robin arbiter: first set request at or above ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);

    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ))
                sum = sum - (IDW+1)'(NREQ);
            idx = sum[IDW-1:0];
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/mac_sched.sv
// Shares one iterative multiplier among NREQ requesters, each with its own 2W accumulator.
// MAC_SCHED_SAT_EN: saturating accumulate with sticky per-requester overflow on rsp_ovf.
module mac_sched
    import mac_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 256,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_clr,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              mul_start,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  logic              mul_done,
    input  logic [2*W-1:0]    mul_p,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [2*W-1:0]    rsp_acc,
`ifdef MAC_SCHED_SAT_EN
    output logic              rsp_ovf,
`endif
    output logic              busy
);

    state_t state, state_nxt;

    logic [NREQ-1:0][W-1:0]   a_v, b_v;
    logic [NREQ-1:0][2*W-1:0] acc;
    logic [NREQ-1:0]          gnt;
    logic [IDW-1:0]           gnt_id, ptr, cur_id;
    logic                     any, hs, cur_clr, done_ok;
    logic [2*W-1:0]           base, acc_new;

    assign a_v = req_a;
    assign b_v = req_b;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (any)
    );

    assign req_ready = (state == S_IDLE) ? gnt : '0;
    assign hs        = (state == S_IDLE) && any;
    assign done_ok   = (state == S_WAIT) && mul_done;
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (hs) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (mul_done) state_nxt = S_ACC;
            S_ACC:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef MAC_SCHED_SAT_EN
    logic [2*W:0]    sum;
    logic [NREQ-1:0] ovf;
    logic            ovf_new;

    always_comb begin
        base    = cur_clr ? '0 : acc[cur_id];
        sum     = {1'b0, base} + {1'b0, mul_p};
        acc_new = sum[2*W] ? '1 : sum[2*W-1:0];
        ovf_new = (!cur_clr && ovf[cur_id]) || sum[2*W];
    end
`else
    always_comb begin
        base    = cur_clr ? '0 : acc[cur_id];
        acc_new = base + mul_p;
    end
`endif

    // The accumulate happens on the mul_done edge so the response is visible during ACC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            cur_id    <= '0;
            cur_clr   <= 1'b0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            acc       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_acc   <= '0;
`ifdef MAC_SCHED_SAT_EN
            ovf       <= '0;
            rsp_ovf   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            mul_start <= hs;
            rsp_valid <= 1'b0;
            if (hs) begin
                mul_a   <= a_v[gnt_id];
                mul_b   <= b_v[gnt_id];
                cur_id  <= gnt_id;
                cur_clr <= req_clr[gnt_id];
            end
            if (done_ok) begin
                acc[cur_id] <= acc_new;
                rsp_valid   <= 1'b1;
                rsp_id      <= cur_id;
                rsp_acc     <= acc_new;
`ifdef MAC_SCHED_SAT_EN
                ovf[cur_id] <= ovf_new;
                rsp_ovf     <= ovf_new;
`endif
            end
            // Just-served requester drops to lowest priority.
            if (state == S_ACC)
                ptr <= (cur_id == IDW'(NREQ-1)) ? '0 : cur_id + 1'b1;
        end
    end

endmodule

// File: tb/tb_mac_sched.sv
// Directed bench for mac_sched with a latency-3 multiplier model and a response scoreboard.
module tb_mac_sched;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;
    localparam int L    = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid, req_ready, req_clr;
    logic [NREQ*W-1:0] req_a, req_b;
    logic              mul_start, mul_done;
    logic [W-1:0]      mul_a, mul_b;
    logic [2*W-1:0]    mul_p;
    logic              rsp_valid, busy;
    logic [IDW-1:0]    rsp_id;
    logic [2*W-1:0]    rsp_acc;
`ifdef MAC_SCHED_SAT_EN
    logic              rsp_ovf;
`endif

    always #5 clk = ~clk;

    mac_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_clr   (req_clr),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_done  (mul_done),
        .mul_p     (mul_p),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_acc   (rsp_acc),
`ifdef MAC_SCHED_SAT_EN
        .rsp_ovf   (rsp_ovf),
`endif
        .busy      (busy)
    );

    // Multiplier model: done pulses L cycles after the start cycle.
    int             cnt;
    logic [2*W-1:0] pa;
    logic           stray = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 0;
            pa  <= '0;
        end else if (mul_start) begin
            cnt <= L;
            pa  <= (2*W)'(mul_a) * (2*W)'(mul_b);
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
        end
    end
    assign mul_done = (cnt == 1) || stray;
    assign mul_p    = pa;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [IDW-1:0] id;
        logic [2*W-1:0] acc;
        logic           ovf;
        int             cyc;
    } exp_t;

    exp_t           sbq[$];
    exp_t           mon_e;
    logic [2*W-1:0] m_acc[NREQ];
    logic           m_ovf[NREQ];
    int             checks = 0;
    int             failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREQ; i++) begin
            m_acc[i] = '0;
            m_ovf[i] = 1'b0;
        end
    endtask

    task automatic push_exp(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic clr, input int hs_cyc);
        exp_t           e;
        logic [2*W:0]   s;
        logic [2*W-1:0] bse;
        bse = clr ? '0 : m_acc[id];
        s   = {1'b0, bse} + (2*W+1)'((2*W)'(a) * (2*W)'(b));
`ifdef MAC_SCHED_SAT_EN
        m_acc[id] = s[2*W] ? '1 : s[2*W-1:0];
        m_ovf[id] = (!clr && m_ovf[id]) || s[2*W];
`else
        m_acc[id] = s[2*W-1:0];
        m_ovf[id] = 1'b0;
`endif
        e.id  = IDW'(id);
        e.acc = m_acc[id];
        e.ovf = m_ovf[id];
        e.cyc = hs_cyc + L + 2;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sbq.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("rsp_id", 64'(rsp_id), 64'(mon_e.id));
                chk("rsp_acc", 64'(rsp_acc), 64'(mon_e.acc));
                chk("rsp_latency", 64'(cyc), 64'(mon_e.cyc));
`ifdef MAC_SCHED_SAT_EN
                chk("rsp_ovf", 64'(rsp_ovf), 64'(mon_e.ovf));
`endif
            end
        end
    end

    task automatic send(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic clr);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        req_valid[id]       = 1'b1;
        req_a[id*W +: W]    = a;
        req_b[id*W +: W]    = b;
        req_clr[id]         = clr;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                got = 1'b1;
                chk("ready_onehot", 64'($onehot0(req_ready)), 64'd1);
                push_exp(id, a, b, clr, cyc);
            end else begin
                @(posedge clk); #1;
            end
        end
        chk("handshake_seen", 64'(got), 64'd1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        req_clr[id]   = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            ok = (sbq.size() == 0) && !busy;
        end
        chk("drain_idle", 64'(ok), 64'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_mul_start"}, 64'(mul_start), 64'd0);
        chk({tag, "_mul_ab"}, 64'({mul_a, mul_b}), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
        chk({tag, "_rsp_acc"}, 64'(rsp_acc), 64'd0);
    endtask

    int order[5] = '{0, 1, 2, 3, 0};

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_clr   = '0;
        req_a     = '0;
        req_b     = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Basic accumulate: 3*5 with clear, then +2*7.
        send(0, 8'd3, 8'd5, 1'b1);
        send(0, 8'd2, 8'd7, 1'b0);
        drain();

        // Fairness with all four requesters held valid, starting from ptr=0.
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = W'(i + 1);
            req_b[i*W +: W] = 8'd2;
        end
        req_clr   = '0;
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            bit found;
            int gid;
            found = 1'b0;
            gid   = -1;
            for (int n = 0; n < 40 && !found; n++) begin
                @(negedge clk);
                if (req_ready != '0) found = 1'b1;
            end
            chk("rr_grant_seen", 64'(found), 64'd1);
            for (int i = 0; i < NREQ; i++)
                if (req_ready[i]) gid = i;
            chk("rr_order", 64'(gid), 64'(order[k]));
            if (gid >= 0) push_exp(gid, W'(gid + 1), 8'd2, 1'b0, cyc);
        end
        @(posedge clk); #1 req_valid = '0;
        drain();

        // Clear on a loaded accumulator leaves the others intact.
        send(2, 8'd10, 8'd10, 1'b1);
        send(2, 8'd4, 8'd4, 1'b1);
        send(1, 8'd0, 8'd0, 1'b0);
        send(0, 8'd0, 8'd0, 1'b0);
        drain();

        // Accumulator boundary: 0xFFF0 + 25.
        send(3, 8'hFF, 8'hFF, 1'b1);
        send(3, 8'd15, 8'd33, 1'b0);
        send(3, 8'd5, 8'd5, 1'b0);
        send(3, 8'd0, 8'd0, 1'b0);
        send(3, 8'd1, 8'd1, 1'b1);
        drain();

        // Stray done while idle.
        @(posedge clk); #1 stray = 1'b1;
        @(posedge clk); #1 stray = 1'b0;
        @(negedge clk);
        chk("stray_busy", 64'(busy), 64'd0);
        chk("stray_mul_start", 64'(mul_start), 64'd0);
        send(1, 8'd1, 8'd1, 1'b0);
        drain();

        // Reset in the middle of WAIT.
        begin
            bit got;
            got = 1'b0;
            @(posedge clk); #1;
            req_valid[0]    = 1'b1;
            req_a[0 +: W]   = 8'd3;
            req_b[0 +: W]   = 8'd3;
            for (int n = 0; n < 40 && !got; n++) begin
                @(negedge clk);
                if (req_ready[0]) got = 1'b1;
                else begin @(posedge clk); #1; end
            end
            chk("wait_handshake_seen", 64'(got), 64'd1);
            @(posedge clk); #1 req_valid[0] = 1'b0;
            @(posedge clk); #1;
            chk("in_wait_busy", 64'(busy), 64'd1);
            rst_n = 1'b0;
            model_clear();
            #1;
            chk_reset_outputs("midrst");
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            @(posedge clk); #1 stray = 1'b1;
            @(posedge clk); #1 stray = 1'b0;
            @(negedge clk);
            chk("late_done_busy", 64'(busy), 64'd0);
            chk("late_done_rsp", 64'(rsp_valid), 64'd0);
        end
        for (int i = 0; i < NREQ; i++)
            send(i, 8'd0, 8'd0, 1'b0);
        drain();

        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mac_sched.md
# mac_sched

Round-robin scheduler that shares one iterative shift-add multiplier among `NREQ` requesters and keeps one `2*W`-bit accumulator per requester. It turns the single multiply-accumulate datapath into a multi-client resource. It sequences each multiply through an explicit start/done handshake and returns the updated accumulator on a shared response bus. It sits between the requester ports and the multiplier core of the MAC512 family.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `W`, default 256: operand width; products and accumulators are `2*W`.
- `IDW`, default 2: requester-ID width, equal to `$clog2(NREQ)`.

Ports, clock and reset first:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit high.
- `req_clr`  in  NREQ  per-requester: zero the accumulator before adding this product.
- `req_a`, `req_b`  in  NREQ*W each  packed operands; requester i occupies slice `[i*W +: W]`.
- `mul_start`  out  1  one-cycle start pulse to the multiplier.
- `mul_a`, `mul_b`  out  W each  registered operands, held stable from start until done.
- `mul_done`  in  1  one-cycle pulse; `mul_p` is valid in the same cycle.
- `mul_p`  in  2W  product.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_id`  out  IDW  requester that owns the response.
- `rsp_acc`  out  2W  updated accumulator value.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE → ISSUE → WAIT → ACC → IDLE.
- **IDLE**
  - The round-robin arbiter picks the first requester with `req_valid` set, searching from `ptr` upward and wrapping modulo NREQ.
  - `req_ready[g]` is driven high combinationally for that requester only.
  - On the handshake (valid & ready): latch `req_a[g]` and `req_b[g]` into `mul_a`/`mul_b`, latch `g` and `req_clr[g]`, then go to ISSUE.
- **ISSUE**: `mul_start`=1 for exactly one cycle, then go to WAIT.
- **WAIT**: hold the operands and wait for `mul_done`. On `mul_done`, latch `mul_p` and go to ACC.
- **ACC**
  - Compute `acc[g] <= (clr ? 0 : acc[g]) + p`, truncated to 2W bits (wrap-around) unless the saturation feature is enabled.
  - Pulse `rsp_valid`. Drive `rsp_id`=g and `rsp_acc` with the new accumulator value.
  - Set `ptr <= g+1` modulo NREQ, then go to IDLE.
- Fairness: a requester that was just served has the lowest priority at the next arbitration.
- Requesters may drop `req_valid` without being served. A request is only committed at the handshake.
- A `mul_done` that arrives outside WAIT is ignored.
- Reset values: state=IDLE, ptr=0, every `acc[i]`=0, `mul_start`=0, `mul_a`=`mul_b`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_acc`=0, `busy`=0.
  - `req_ready` is combinational and may be high in IDLE right after reset.
- Reset asserted mid-operation clears all state, including accumulators. The multiplier is reset by the same `rst_n`.

## Timing
- Cycle T: handshake.
- T+1: `mul_start`=1.
- The multiplier asserts `mul_done` at T+1+L, where L ≥ 1 is the multiplier latency (256 for the W=256 shift-add core).
- T+2+L: `rsp_valid`=1.
- T+3+L: IDLE; the next handshake can occur in this cycle.
- Throughput: one operation per L+3 cycles.
- Every registered output changes only on the rising edge of `clk`.

## Configuration
- `MAC_SCHED_SAT_EN`
  - Defined: the accumulate step is unsigned saturating. When the sum carries out of 2W bits, `acc` is set to all-ones. A sticky per-requester `ovf` bit is set; it is cleared by `req_clr` and exposed on an extra `rsp_ovf` output, valid alongside `rsp_valid`.
  - Undefined: the sum wraps modulo 2^(2W). There is no `rsp_ovf` port.

## Structure
- Package `mac_sched_pkg` holds:
  - the FSM state enum (IDLE, ISSUE, WAIT, ACC);
  - the localparams for the state encoding width;
  - the ID-width helper function.
- Sub-module `rr_arbiter`, parameterised by NREQ. It is purely combinational apart from its input pointer.
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot `gnt`, encoded `gnt_id`, `any`.

## Test plan
- Single requester, NREQ=4, L=3 model:
  - Req0 sends a=3, b=5, clr=1. Response: `rsp_id`=0, `rsp_acc`=15, `rsp_valid` at handshake+5.
  - Req0 then sends a=2, b=7, clr=0. Response: `rsp_acc`=29.
- All four requesters held valid continuously: grant order 0,1,2,3,0. No requester is served twice before the others are served once.
- `req_clr`=1 on a requester whose accumulator holds 100, with a=4, b=4: `rsp_acc`=16. Other requesters' accumulators are unchanged.
- Wrap-around (macro off), W=8: accumulator holds 0xFFF0, a=b=5. `rsp_acc`=0x0009.
  - Same case with `MAC_SCHED_SAT_EN` defined: `rsp_acc`=0xFFFF and `rsp_ovf`=1.
- `rst_n` pulsed low during WAIT:
  - All outputs return to their reset values and the accumulators read 0.
  - No `rsp_valid` is emitted.
  - A late `mul_done` after reset is ignored.
- Stray `mul_done` while in IDLE: no state change and no response.
